// File: rtl/lc3_regfile_pipe.sv
// LC-3 style register file with write-through bypass, a busy-bit scoreboard,
// condition codes and a multiplexed display port (manual or auto-scan).
module lc3_regfile_pipe #(
    parameter int DW       = 16,
    parameter int AW       = 3,
    parameter int NREG     = 8,
    parameter int SCAN_DIV = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd,
    input  logic          cc_we,
    input  logic          rsv,
    input  logic [AW-1:0] rsv_a,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    output logic [DW-1:0] rd1,
    output logic [DW-1:0] rd2,
    output logic          busy1,
    output logic          busy2,
    output logic [2:0]    nzp,
    input  logic [3:0]    dis_sw,
    output logic [AW-1:0] dis_idx,
    output logic [DW-1:0] dis_reg
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [DW-1:0]   regs [NREG];
    logic [NREG-1:0] busy;
    logic [AW-1:0]   scan_idx;
    logic [PW-1:0]   prescale;
    logic            wr_en;
    logic            byp1;
    logic            byp2;
    logic            auto_mode;

    // Writes are ignored while reset is held, including the read bypass.
    assign wr_en     = we & ~rst;
    assign auto_mode = dis_sw[3];

    function automatic logic [2:0] cc_of(input logic [DW-1:0] v);
        if (v[DW-1])      return 3'b100;
        else if (v == '0) return 3'b010;
        else              return 3'b001;
    endfunction

    // NOTE: the array is reset explicitly because reset must clear every architectural register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
            nzp <= 3'b010;
        end else if (we) begin
            // NOTE: non-blocking assignments keep every state update tied to the same edge.
            regs[wa] <= wd;
            if (cc_we) nzp <= cc_of(wd);
        end
    end

    // A reservation on the same edge as the write to that register keeps it busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (rsv && rsv_a == AW'(i))    busy[i] <= 1'b1;
                else if (we && wa == AW'(i))   busy[i] <= 1'b0;
            end
        end
    end

    // Prescaler and scan index freeze in manual mode and resume from there.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_idx <= '0;
            prescale <= '0;
        end else if (auto_mode) begin
            if (prescale == PW'(SCAN_DIV - 1)) begin
                prescale <= '0;
                scan_idx <= (scan_idx == AW'(NREG - 1)) ? '0 : scan_idx + 1'b1;
            end else begin
                prescale <= prescale + 1'b1;
            end
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        byp1    = 1'b0;
        byp2    = 1'b0;
        rd1     = regs[ra1];
        rd2     = regs[ra2];
        busy1   = busy[ra1];
        busy2   = busy[ra2];
        dis_idx = dis_sw[AW-1:0];
        if (wr_en && wa == ra1) byp1 = 1'b1;
        if (wr_en && wa == ra2) byp2 = 1'b1;
        if (byp1) begin
            rd1   = wd;
            busy1 = 1'b0;
        end
        if (byp2) begin
            rd2   = wd;
            busy2 = 1'b0;
        end
        if (auto_mode) dis_idx = scan_idx;
    end

    // The display shows committed state only, never the in-flight write.
    assign dis_reg = regs[dis_idx];

endmodule

// File: tb/tb_lc3_regfile_pipe.sv
// Self-checking bench for lc3_regfile_pipe: directed scenarios followed by
// random traffic, compared against a behavioural model of the register file.
module tb_lc3_regfile_pipe;

    localparam int DW       = 16;
    localparam int AW       = 3;
    localparam int NREG     = 8;
    localparam int SCAN_DIV = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          cc_we;
    logic          rsv;
    logic [AW-1:0] rsv_a;
    logic [AW-1:0] ra1;
    logic [AW-1:0] ra2;
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;
    logic          busy1;
    logic          busy2;
    logic [2:0]    nzp;
    logic [3:0]    dis_sw;
    logic [AW-1:0] dis_idx;
    logic [DW-1:0] dis_reg;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [DW-1:0] m_r    [NREG];
    logic          m_busy [NREG];
    logic [2:0]    m_nzp;
    int            auto_cycles;

    lc3_regfile_pipe #(.DW(DW), .AW(AW), .NREG(NREG), .SCAN_DIV(SCAN_DIV)) dut (
        .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd), .cc_we(cc_we),
        .rsv(rsv), .rsv_a(rsv_a), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .busy1(busy1), .busy2(busy2), .nzp(nzp), .dis_sw(dis_sw),
        .dis_idx(dis_idx), .dis_reg(dis_reg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) begin
            m_r[i]    = '0;
            m_busy[i] = 1'b0;
        end
        m_nzp       = 3'b010;
        auto_cycles = 0;
    endtask

    task automatic set_idle();
        we = 1'b0; wa = '0; wd = '0; cc_we = 1'b0;
        rsv = 1'b0; rsv_a = '0; ra1 = '0; ra2 = '0;
    endtask

    // Compare every output against what the model says it should be right now.
    task automatic check_outputs(input string tag);
        logic          live_we;
        logic [AW-1:0] exp_idx;
        live_we = we && !rst;
        check({tag, ".rd1"}, rd1, (live_we && wa == ra1) ? wd : m_r[ra1]);
        check({tag, ".rd2"}, rd2, (live_we && wa == ra2) ? wd : m_r[ra2]);
        check({tag, ".busy1"}, DW'(busy1), DW'(m_busy[ra1] && !(live_we && wa == ra1)));
        check({tag, ".busy2"}, DW'(busy2), DW'(m_busy[ra2] && !(live_we && wa == ra2)));
        check({tag, ".nzp"}, DW'(nzp), DW'(m_nzp));
        check({tag, ".nzp_onehot"}, DW'($countones(nzp)), DW'(1));
        exp_idx = dis_sw[3] ? AW'((auto_cycles / SCAN_DIV) % NREG) : dis_sw[AW-1:0];
        check({tag, ".dis_idx"}, DW'(dis_idx), DW'(exp_idx));
        check({tag, ".dis_reg"}, dis_reg, m_r[exp_idx]);
    endtask

    // Apply the current inputs to the model, then advance the DUT one edge.
    task automatic tick();
        if (!rst) begin
            if (we) begin
                m_r[wa]    = wd;
                m_busy[wa] = 1'b0;
                if (cc_we) m_nzp = wd[DW-1] ? 3'b100 : ((wd == '0) ? 3'b010 : 3'b001);
            end
            if (rsv) m_busy[rsv_a] = 1'b1;
            if (dis_sw[3]) auto_cycles++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        dis_sw = 4'b0000;
        set_idle();
        model_reset();
        #12;
        check_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_outputs("reset_release");

        // Write-through bypass, then stored value
        we = 1'b1; wa = 3'd3; wd = 16'h1234; ra1 = 3'd3; ra2 = 3'd4;
        #1;
        check("r020.bypass", rd1, 16'h1234);
        check_outputs("r020.pre");
        tick();
        we = 1'b0;
        #1;
        check("r020.stored", rd1, 16'h1234);
        check("r020.rd2_zero", rd2, 16'h0000);
        check_outputs("r020.post");

        // Reserve then clear by write
        rsv = 1'b1; rsv_a = 3'd5;
        tick();
        rsv = 1'b0; ra1 = 3'd5;
        #1;
        check("r021.busy_set", DW'(busy1), DW'(1));
        we = 1'b1; wa = 3'd5; wd = 16'h00a5;
        #1;
        check("r021.busy_bypass", DW'(busy1), DW'(0));
        tick();
        we = 1'b0;
        #1;
        check("r021.busy_cleared", DW'(busy1), DW'(0));
        check_outputs("r021");

        // Reserve and write to the same register on one edge
        rsv = 1'b1; rsv_a = 3'd2; we = 1'b1; wa = 3'd2; wd = 16'd7;
        tick();
        set_idle();
        ra1 = 3'd2;
        #1;
        check("r022.data", rd1, 16'd7);
        check("r022.busy", DW'(busy1), DW'(1));
        check_outputs("r022");

        // Condition codes
        we = 1'b1; cc_we = 1'b1; wa = 3'd1; wd = 16'h8000;
        tick();
        check("r023.neg", DW'(nzp), DW'(3'b100));
        wd = 16'h0000;
        tick();
        check("r023.zero", DW'(nzp), DW'(3'b010));
        wd = 16'h0001;
        tick();
        check("r023.pos", DW'(nzp), DW'(3'b001));
        we = 1'b0; wd = 16'h8000;
        tick();
        check("r023.ignored", DW'(nzp), DW'(3'b001));
        check_outputs("r023");

        // Auto-scan stepping and wrap, then manual override
        set_idle();
        we = 1'b1; wa = 3'd6; wd = 16'hbeef;
        tick();
        set_idle();
        dis_sw = 4'b1000;
        #1;
        check("r024.start", DW'(dis_idx), DW'(0));
        for (int k = 0; k < 36; k++) begin
            tick();
            check($sformatf("r024.scan%0d", k), DW'(dis_idx), DW'(((k + 1) / SCAN_DIV) % NREG));
        end
        check_outputs("r024.auto");
        dis_sw = 4'b0110;
        #1;
        check("r024.manual_idx", DW'(dis_idx), DW'(6));
        check("r024.manual_reg", dis_reg, 16'hbeef);
        tick();
        tick();
        dis_sw = 4'b1000;
        #1;
        check_outputs("r015.resume");

        // Mid-cycle reset after writes and reservations
        we = 1'b1; wa = 3'd4; wd = 16'h4444; rsv = 1'b1; rsv_a = 3'd7;
        tick();
        tick();
        set_idle();
        ra1 = 3'd4; ra2 = 3'd7;
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check("r025.rd1", rd1, 16'h0000);
        check("r025.busy2", DW'(busy2), DW'(0));
        check("r025.nzp", DW'(nzp), DW'(3'b010));
        check("r025.dis_idx", DW'(dis_idx), DW'(0));
        check_outputs("r025");
        we = 1'b1; wa = 3'd1; wd = 16'h8001; cc_we = 1'b1; rsv = 1'b1; rsv_a = 3'd2; ra1 = 3'd2;
        tick();
        check_outputs("r018.held");
        @(negedge clk);
        rst = 1'b0;
        set_idle();
        #1;
        check_outputs("r019.release");
        we = 1'b1; wa = 3'd3; wd = 16'h0055; ra1 = 3'd3;
        tick();
        we = 1'b0;
        #1;
        check("r019.first_edge", rd1, 16'h0055);
        check_outputs("r019.first");

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            we     = ($urandom_range(0, 1) == 1);
            wa     = AW'($urandom);
            case ($urandom_range(0, 3))
                0:       wd = '0;
                1:       wd = 16'h8000 | DW'($urandom);
                default: wd = DW'($urandom);
            endcase
            cc_we  = ($urandom_range(0, 1) == 1);
            rsv    = ($urandom_range(0, 2) == 0);
            rsv_a  = AW'($urandom);
            ra1    = AW'($urandom);
            ra2    = ($urandom_range(0, 3) == 0) ? ra1 : AW'($urandom);
            if ($urandom_range(0, 15) == 0) dis_sw = 4'($urandom);
            #1;
            check_outputs($sformatf("rand%0d", n));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lc3_regfile_pipe.md
LC3_REGFILE_PIPE -- requirements
Module: lc3_regfile_pipe

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  DW  16  data word width
  AW  3  register address width
  NREG  8  register count (2**AW)
  SCAN_DIV  4  clk cycles per auto-scan display step (>=1)
REQ-002 Ports (name  direction  width  meaning), one per line:
  clk  in  1  clock, all state updates on rising edge
  rst  in  1  reset, asynchronous, active-high
  we  in  1  write enable
  wa  in  AW  write address
  wd  in  DW  write data
  cc_we  in  1  update condition codes from wd when we=1
  rsv  in  1  reserve register rsv_a (mark busy)
  rsv_a  in  AW  address to reserve
  ra1  in  AW  read address port 1
  ra2  in  AW  read address port 2
  rd1  out  DW  read data port 1
  rd2  out  DW  read data port 2
  busy1  out  1  register ra1 has a pending write
  busy2  out  1  register ra2 has a pending write
  nzp  out  3  condition codes {N,Z,P}
  dis_sw  in  4  display control: [3]=1 auto-scan, [AW-1:0] manual index
  dis_idx  out  AW  index of register displayed
  dis_reg  out  DW  value of register displayed

Function
REQ-003 Register array: NREG x DW; write R[wa]<=wd on rising clk when we=1.
REQ-004 Reads combinational; rd1=R[ra1], rd2=R[ra2].
REQ-005 Write-through bypass: when we=1 and wa==ra1 (ra2), rd1 (rd2) SHALL equal wd same cycle.
REQ-006 Both read ports with same address SHALL return identical data, including bypass.
REQ-007 Scoreboard: busy bit per register; rsv=1 sets busy[rsv_a] at clk edge.
REQ-008 we=1 clears busy[wa] at clk edge; write to non-busy register legal, busy stays 0.
REQ-009 rsv=1 and we=1 with rsv_a==wa same edge: register written AND busy stays 1 (reserve wins).
REQ-010 busy1/busy2 = busy[ra1]/busy[ra2], combinational; a same-cycle write to that address SHALL force busyN=0 (bypass valid).
REQ-011 cc_we=1 with we=1: nzp<=100 if wd[DW-1]=1, 010 if wd==0, else 001; exactly one bit set at all times.
REQ-012 cc_we=1 with we=0 SHALL be ignored.
REQ-013 Display manual mode (dis_sw[3]=0): dis_idx=dis_sw[AW-1:0], combinational.
REQ-014 Auto-scan (dis_sw[3]=1): prescaler counts 0..SCAN_DIV-1; on terminal count scan index increments, wrapping NREG-1->0; dis_idx=scan index.
REQ-015 Scan index and prescaler hold value in manual mode; resume from held value on re-entry.
REQ-016 dis_reg=R[dis_idx], no bypass (registered state only).

Reset
REQ-017 rst=1 asynchronously: all R[i]=0, all busy=0, nzp=010, scan index=0, prescaler=0.
REQ-018 While rst=1, we, rsv, cc_we SHALL be ignored; outputs reflect reset state.
REQ-019 rst asserted mid-scan or with pending reservations SHALL discard them; first edge after deassert behaves as normal operation.

Verification
REQ-020 rst, then we=1 wa=3 wd=16'h1234, ra1=3 same cycle -> rd1=16'h1234 before edge; after edge, we=0 -> rd1=16'h1234, rd2(ra2=4)=0.
REQ-021 rsv=1 rsv_a=5; next cycle ra1=5 -> busy1=1; we=1 wa=5 -> busy1=0 same cycle, busy[5]=0 after edge.
REQ-022 rsv=1 rsv_a=2 with we=1 wa=2 wd=7 -> R[2]=7, busy[2]=1 after edge.
REQ-023 cc_we=1 writes of 16'h8000, 0, 16'h0001 -> nzp=100, 010, 001; cc_we=1 with we=0 -> nzp unchanged.
REQ-024 dis_sw=4'b1000, SCAN_DIV=4 -> dis_idx steps every 4 cycles 0..7 then 0; switch to manual dis_sw=4'b0110 -> dis_idx=6, dis_reg=R[6].
REQ-025 rst pulse asserted between clock edges after several writes/reservations -> immediately all reads 0, busy 0, nzp=010, dis_idx=0 in auto mode.
